// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the CPU datapath slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int IR_W       = 8;

    // Bus source select (bflag)
    typedef enum logic [2:0] {
        BUS_ZERO = 3'd0,
        BUS_PC   = 3'd1,
        BUS_R1   = 3'd2,
        BUS_R2   = 3'd3,
        BUS_R3   = 3'd4,
        BUS_R    = 3'd5,
        BUS_AC   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    // ALU operation (alu)
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_PASS = 3'd2,
        ALU_CLR  = 3'd3,
        ALU_DEC  = 3'd4,
        ALU_MUL4 = 3'd5,
        ALU_DIV2 = 3'd6,
        ALU_RSVD = 3'd7
    } alu_op_e;

    // cflag bit indices
    localparam int C_WR = 0;
    localparam int C_AC = 1;
    localparam int C_R  = 2;
    localparam int C_R3 = 3;
    localparam int C_R2 = 4;
    localparam int C_R1 = 5;
    localparam int C_PC = 6;
    localparam int C_AR = 7;

endpackage

// File: rtl/cpu_if.sv
// Controller/memory-facing signal bundle of the CPU datapath.
// Latency: n/a (wires only).
// Backpressure: none; strobes are consumed every cycle.
// master: drives strobes, bflag/alu/cflag and mem_rdata; observes ir, z, memory port, halt and debug.
// slave : the datapath side of the same signals.
interface cpu_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              pcinc;
    logic              r1inc;
    logic              r2inc;
    logic              r3inc;
    logic              acinc;
    logic              fetch;
    logic              finish;
    logic [2:0]        bflag;
    logic [2:0]        alu;
    logic [7:0]        cflag;

    logic [IR_W-1:0]   ir;
    logic              z;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              halted;
    logic [DATA_W-1:0] ac_dbg;
    logic [ADDR_W-1:0] pc_dbg;

    modport master (
        output pcinc, r1inc, r2inc, r3inc, acinc, fetch, finish,
        output bflag, alu, cflag, mem_rdata,
        input  ir, z, mem_addr, mem_wdata, mem_we, halted, ac_dbg, pc_dbg
    );

    modport slave (
        input  pcinc, r1inc, r2inc, r3inc, acinc, fetch, finish,
        input  bflag, alu, cflag, mem_rdata,
        output ir, z, mem_addr, mem_wdata, mem_we, halted, ac_dbg, pc_dbg
    );

endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: y = f(op, a=AC, b=bus), modulo 2^DATA_W, carry/borrow dropped.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (DATA_W operands), op (3-bit alu_op_e), y (DATA_W result).
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = a;
        case (alu_op_e'(op))
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_PASS: y = b;
            ALU_CLR:  y = '0;
            ALU_DEC:  y = a - DATA_W'(1);
            ALU_MUL4: y = a << 2;
            ALU_DIV2: y = a >> 1;
            ALU_RSVD: y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Register file, bus mux, ALU and memory port of the CPU, driven by controller strobes.
// Latency: strobes sampled at edge N are visible after edge N; memory port is combinational.
// Backpressure: none; once halted every state update and mem_we is suppressed until rst.
// Ports: clk, rst (sync, active-high); ctl (cpu_if.slave) carries strobes, memory port, ir/z and debug.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    cpu_if.slave  ctl
);

    // Architectural state
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ar;
    logic [IR_W-1:0]   ir_q;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] r3;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] ac;
    logic              z_q;
    logic              halted_q;
    logic              fetch_d;

    // Combinational datapath
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_y;

    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] ar_nxt;
    logic [DATA_W-1:0] r1_nxt;
    logic [DATA_W-1:0] r2_nxt;
    logic [DATA_W-1:0] r3_nxt;
    logic [DATA_W-1:0] r_nxt;
    logic [DATA_W-1:0] ac_nxt;
    logic              ac_wr;

    always_comb begin
        bus = '0;
        case (bus_sel_e'(ctl.bflag))
            BUS_ZERO: bus = '0;
            BUS_PC:   bus = DATA_W'(pc);
            BUS_R1:   bus = r1;
            BUS_R2:   bus = r2;
            BUS_R3:   bus = r3;
            BUS_R:    bus = r;
            BUS_AC:   bus = ac;
            BUS_MEM:  bus = ctl.mem_rdata;
            default:  bus = '0;
        endcase
    end

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a  (ac),
        .b  (bus),
        .op (ctl.alu),
        .y  (alu_y)
    );

    // Next-state selection. A bus load always beats an increment on the
    // same register; fetch beats an explicit AR load.
    always_comb begin
        ar_nxt = ar;
        if (ctl.fetch) begin
            ar_nxt = pc;
        end else if (ctl.cflag[C_AR]) begin
            ar_nxt = ADDR_W'(bus);
        end

        pc_nxt = pc;
        if (ctl.cflag[C_PC]) begin
            pc_nxt = ADDR_W'(bus);
        end else if (ctl.pcinc) begin
            pc_nxt = pc + ADDR_W'(1);
        end

        r1_nxt = r1;
        if (ctl.cflag[C_R1]) begin
            r1_nxt = bus;
        end else if (ctl.r1inc) begin
            r1_nxt = r1 + DATA_W'(1);
        end

        r2_nxt = r2;
        if (ctl.cflag[C_R2]) begin
            r2_nxt = bus;
        end else if (ctl.r2inc) begin
            r2_nxt = r2 + DATA_W'(1);
        end

        r3_nxt = r3;
        if (ctl.cflag[C_R3]) begin
            r3_nxt = bus;
        end else if (ctl.r3inc) begin
            r3_nxt = r3 + DATA_W'(1);
        end

        r_nxt = r;
        if (ctl.cflag[C_R]) begin
            r_nxt = bus;
        end

        ac_nxt = ac;
        if (ctl.cflag[C_AC]) begin
            ac_nxt = alu_y;
        end else if (ctl.acinc) begin
            ac_nxt = ac + DATA_W'(1);
        end

        // z tracks AC only on edges that actually write AC
        ac_wr = ctl.cflag[C_AC] | ctl.acinc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            ar       <= '0;
            ir_q     <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            r        <= '0;
            ac       <= '0;
            z_q      <= 1'b1;
            halted_q <= 1'b0;
            fetch_d  <= 1'b0;
        end else if (!halted_q) begin
            pc      <= pc_nxt;
            ar      <= ar_nxt;
            r1      <= r1_nxt;
            r2      <= r2_nxt;
            r3      <= r3_nxt;
            r       <= r_nxt;
            ac      <= ac_nxt;
            if (ac_wr) begin
                z_q <= (ac_nxt == '0);
            end
            // IR captures the word addressed by the AR loaded on the fetch edge
            if (fetch_d) begin
                ir_q <= IR_W'(ctl.mem_rdata);
            end
            fetch_d <= ctl.fetch;
            // Strobes on the finish edge still land; freezing starts next edge
            if (ctl.finish) begin
                halted_q <= 1'b1;
            end
        end else begin
            fetch_d <= 1'b0;
        end
    end

    // Memory port: write uses the current (pre-edge) AR
    assign ctl.mem_addr  = ar;
    assign ctl.mem_wdata = bus;
    assign ctl.mem_we    = ctl.cflag[C_WR] & ~halted_q;

    assign ctl.ir     = ir_q;
    assign ctl.z      = z_q;
    assign ctl.halted = halted_q;
    assign ctl.ac_dbg = ac;
    assign ctl.pc_dbg = pc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized strobes against a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_datapath;
    import cpu_pkg::*;

    typedef struct packed {
        logic       pcinc;
        logic       r1inc;
        logic       r2inc;
        logic       r3inc;
        logic       acinc;
        logic       fetch;
        logic       finish;
        logic [2:0] bflag;
        logic [2:0] alu;
        logic [7:0] cflag;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_if #(.DATA_W(8), .ADDR_W(8)) dp();

    // Simple asynchronous-read memory for the datapath
    logic [7:0] mem [256];
    assign dp.mem_rdata = mem[dp.mem_addr];
    always @(posedge clk) begin
        if (dp.mem_we) mem[dp.mem_addr] <= dp.mem_wdata;
    end

    cpu_datapath #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (dp)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_pc, m_ar, m_ir, m_r1, m_r2, m_r3, m_r, m_ac;
    logic       m_z, m_halted, m_fd;
    stim_t      cur;
    logic       cur_rst;

    function automatic logic [7:0] inc8(input logic [7:0] v);
        return 8'((int'(v) + 1) % 256);
    endfunction

    function automatic logic [7:0] m_alu(input logic [2:0] op, input logic [7:0] a8, input logic [7:0] b8);
        int a, b, res;
        a = int'(a8);
        b = int'(b8);
        case (op)
            3'd0: res = (a + b) % 256;
            3'd1: res = (a - b + 256) % 256;
            3'd2: res = b;
            3'd3: res = 0;
            3'd4: res = (a + 255) % 256;
            3'd5: res = (a * 4) % 256;
            3'd6: res = a / 2;
            default: res = a;
        endcase
        return 8'(res);
    endfunction

    function automatic logic [7:0] mbus(input logic [2:0] sel);
        case (sel)
            3'd0: return 8'h00;
            3'd1: return m_pc;
            3'd2: return m_r1;
            3'd3: return m_r2;
            3'd4: return m_r3;
            3'd5: return m_r;
            3'd6: return m_ac;
            default: return mem[m_ar];
        endcase
    endfunction

    task automatic drive(input stim_t s, input logic r);
        cur       = s;
        cur_rst   = r;
        rst       = r;
        dp.pcinc  = s.pcinc;
        dp.r1inc  = s.r1inc;
        dp.r2inc  = s.r2inc;
        dp.r3inc  = s.r3inc;
        dp.acinc  = s.acinc;
        dp.fetch  = s.fetch;
        dp.finish = s.finish;
        dp.bflag  = s.bflag;
        dp.alu    = s.alu;
        dp.cflag  = s.cflag;
    endtask

    // Advance one clock edge, moving the model by the rules of one cycle.
    task automatic tick();
        logic [7:0] b, y, n_pc, n_ar, n_ir, n_r1, n_r2, n_r3, n_r, n_ac;
        b = mbus(cur.bflag);
        y = m_alu(cur.alu, m_ac, b);
        if (cur_rst) begin
            {m_pc, m_ar, m_ir, m_r1, m_r2, m_r3, m_r, m_ac} = '0;
            m_z = 1'b1; m_halted = 1'b0; m_fd = 1'b0;
        end else if (!m_halted) begin
            n_ir = m_fd ? mem[m_ar] : m_ir;
            n_ar = cur.fetch ? m_pc : (cur.cflag[7] ? b : m_ar);
            n_pc = cur.cflag[6] ? b : (cur.pcinc ? inc8(m_pc) : m_pc);
            n_r1 = cur.cflag[5] ? b : (cur.r1inc ? inc8(m_r1) : m_r1);
            n_r2 = cur.cflag[4] ? b : (cur.r2inc ? inc8(m_r2) : m_r2);
            n_r3 = cur.cflag[3] ? b : (cur.r3inc ? inc8(m_r3) : m_r3);
            n_r  = cur.cflag[2] ? b : m_r;
            n_ac = cur.cflag[1] ? y : (cur.acinc ? inc8(m_ac) : m_ac);
            if (cur.cflag[1] || cur.acinc) m_z = (n_ac == 8'h00);
            {m_pc, m_ar, m_ir, m_r1, m_r2, m_r3, m_r, m_ac} = {n_pc, n_ar, n_ir, n_r1, n_r2, n_r3, n_r, n_ac};
            m_fd = cur.fetch;
            if (cur.finish) m_halted = 1'b1;
        end else begin
            m_fd = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input stim_t s, input logic r);
        drive(s, r);
        tick();
    endtask

    // Put a value on the bus (via memory at current AR) and load it into one destination.
    task automatic set_reg(input int idx, input logic [7:0] v);
        stim_t s;
        s = '0;
        mem[m_ar] = v;
        s.bflag = 3'd7;
        s.alu   = 3'd2;
        s.cflag = 8'(1 << idx);
        step(s, 1'b0);
    endtask

    // Show a bus source on mem_wdata without clocking.
    task automatic peek(input logic [2:0] sel);
        stim_t s;
        s = '0;
        s.bflag = sel;
        drive(s, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        for (int i = 0; i < 2; i++) begin
            s = stim_t'($urandom);
            step(s, 1'b1);
        end
        drive('0, 1'b0);
        #1;
        checks++; if (dp.pc_dbg !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", dp.pc_dbg); end
        checks++; if (dp.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_ar: got %h want 00", dp.mem_addr); end
        checks++; if (dp.ac_dbg !== 8'h00) begin errors++; $display("FAIL reset_ac: got %h want 00", dp.ac_dbg); end
        checks++; if (dp.ir !== 8'h00) begin errors++; $display("FAIL reset_ir: got %h want 00", dp.ir); end
        checks++; if (dp.z !== 1'b1) begin errors++; $display("FAIL reset_z: got %b want 1", dp.z); end
        checks++; if (dp.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", dp.halted); end
        checks++; if (dp.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", dp.mem_we); end
        for (int k = 2; k <= 5; k++) begin
            peek(3'(k));
            checks++; if (dp.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", k, dp.mem_wdata); end
        end
    endtask

    task automatic test_fetch();
        stim_t s;
        mem[0] = 8'h0E;
        s = '0; s.fetch = 1'b1;
        step(s, 1'b0);
        checks++; if (dp.mem_addr !== 8'h00) begin errors++; $display("FAIL fetch_ar: got %h want 00", dp.mem_addr); end
        s = '0; s.pcinc = 1'b1;
        step(s, 1'b0);
        checks++; if (dp.ir !== 8'h0E) begin errors++; $display("FAIL fetch_ir: got %h want 0e", dp.ir); end
        checks++; if (dp.pc_dbg !== 8'h01) begin errors++; $display("FAIL fetch_pc: got %h want 01", dp.pc_dbg); end
    endtask

    task automatic test_add_sub();
        stim_t s;
        set_reg(C_AC, 8'hF0);
        set_reg(C_R, 8'h20);
        s = '0; s.bflag = 3'd5; s.alu = 3'd0; s.cflag = 8'h02;
        step(s, 1'b0);
        checks++; if (dp.ac_dbg !== 8'h10) begin errors++; $display("FAIL add_ac: got %h want 10", dp.ac_dbg); end
        checks++; if (dp.z !== 1'b0) begin errors++; $display("FAIL add_z: got %b want 0", dp.z); end
        set_reg(C_R, 8'h10);
        s.alu = 3'd1;
        step(s, 1'b0);
        checks++; if (dp.ac_dbg !== 8'h00) begin errors++; $display("FAIL sub_ac: got %h want 00", dp.ac_dbg); end
        checks++; if (dp.z !== 1'b1) begin errors++; $display("FAIL sub_z: got %b want 1", dp.z); end
    endtask

    task automatic test_precedence();
        stim_t s;
        mem[m_ar] = 8'h44;
        s = '0; s.bflag = 3'd7; s.cflag = 8'hE0; s.r1inc = 1'b1; s.pcinc = 1'b1;
        step(s, 1'b0);
        checks++; if (dp.pc_dbg !== 8'h44) begin errors++; $display("FAIL prec_pc: got %h want 44", dp.pc_dbg); end
        checks++; if (dp.mem_addr !== 8'h44) begin errors++; $display("FAIL prec_ar: got %h want 44", dp.mem_addr); end
        peek(3'd2);
        checks++; if (dp.mem_wdata !== 8'h44) begin errors++; $display("FAIL prec_r1: got %h want 44", dp.mem_wdata); end
    endtask

    task automatic test_wrap_shift();
        stim_t s;
        set_reg(C_AC, 8'hFF);
        s = '0; s.acinc = 1'b1;
        step(s, 1'b0);
        checks++; if (dp.ac_dbg !== 8'h00) begin errors++; $display("FAIL wrap_ac: got %h want 00", dp.ac_dbg); end
        checks++; if (dp.z !== 1'b1) begin errors++; $display("FAIL wrap_z: got %b want 1", dp.z); end
        set_reg(C_AC, 8'h81);
        s = '0; s.alu = 3'd6; s.cflag = 8'h02;
        step(s, 1'b0);
        checks++; if (dp.ac_dbg !== 8'h40) begin errors++; $display("FAIL div2_ac: got %h want 40", dp.ac_dbg); end
        set_reg(C_AC, 8'h81);
        s.alu = 3'd5;
        step(s, 1'b0);
        checks++; if (dp.ac_dbg !== 8'h04) begin errors++; $display("FAIL mul4_ac: got %h want 04", dp.ac_dbg); end
    endtask

    task automatic test_store();
        stim_t s;
        set_reg(C_AC, 8'h5A);
        set_reg(C_AR, 8'h20);
        mem[8'h20] = 8'hA5;
        mem[8'h00] = 8'h77;
        s = '0; s.bflag = 3'd6; s.cflag = 8'h01;
        drive(s, 1'b0);
        #1;
        checks++; if (dp.mem_we !== 1'b1) begin errors++; $display("FAIL store_we: got %b want 1", dp.mem_we); end
        checks++; if (dp.mem_addr !== 8'h20) begin errors++; $display("FAIL store_addr: got %h want 20", dp.mem_addr); end
        checks++; if (dp.mem_wdata !== 8'h5A) begin errors++; $display("FAIL store_wdata: got %h want 5a", dp.mem_wdata); end
        tick();
        peek(3'd7);
        checks++; if (dp.mem_wdata !== 8'h5A) begin errors++; $display("FAIL store_readback: got %h want 5a", dp.mem_wdata); end
        // Write plus AR load together: the write lands at the old AR
        s = '0; s.bflag = 3'd0; s.cflag = 8'h81;
        step(s, 1'b0);
        checks++; if (mem[8'h20] !== 8'h00) begin errors++; $display("FAIL store_oldar: got %h want 00", mem[8'h20]); end
        checks++; if (mem[8'h00] !== 8'h77) begin errors++; $display("FAIL store_newar_untouched: got %h want 77", mem[8'h00]); end
        checks++; if (dp.mem_addr !== 8'h00) begin errors++; $display("FAIL store_ar_load: got %h want 00", dp.mem_addr); end
    endtask

    task automatic test_halt();
        stim_t s;
        logic [7:0] pc0, ac0, ar0, r1_0;
        logic       z0;
        s = '0; s.finish = 1'b1; s.pcinc = 1'b1;
        pc0 = inc8(m_pc);
        step(s, 1'b0);
        checks++; if (dp.halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", dp.halted); end
        checks++; if (dp.pc_dbg !== pc0) begin errors++; $display("FAIL halt_last_inc: got %h want %h", dp.pc_dbg, pc0); end
        ac0 = m_ac; ar0 = m_ar; z0 = m_z; r1_0 = m_r1;
        s = '0; s.pcinc = 1'b1; s.acinc = 1'b1; s.r1inc = 1'b1; s.fetch = 1'b1;
        s.cflag = 8'hFF; s.bflag = 3'd7; s.alu = 3'd0;
        drive(s, 1'b0);
        #1;
        checks++; if (dp.mem_we !== 1'b0) begin errors++; $display("FAIL halt_we: got %b want 0", dp.mem_we); end
        tick();
        checks++; if (dp.pc_dbg !== pc0) begin errors++; $display("FAIL halt_pc: got %h want %h", dp.pc_dbg, pc0); end
        checks++; if (dp.ac_dbg !== ac0) begin errors++; $display("FAIL halt_ac: got %h want %h", dp.ac_dbg, ac0); end
        checks++; if (dp.mem_addr !== ar0) begin errors++; $display("FAIL halt_ar: got %h want %h", dp.mem_addr, ar0); end
        checks++; if (dp.z !== z0) begin errors++; $display("FAIL halt_z: got %b want %b", dp.z, z0); end
        peek(3'd2);
        checks++; if (dp.mem_wdata !== r1_0) begin errors++; $display("FAIL halt_r1: got %h want %h", dp.mem_wdata, r1_0); end
        s = stim_t'($urandom);
        step(s, 1'b1);
        checks++; if (dp.halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b want 0", dp.halted); end
        checks++; if (dp.pc_dbg !== 8'h00) begin errors++; $display("FAIL halt_rst_pc: got %h want 00", dp.pc_dbg); end
    endtask

    task automatic test_random();
        stim_t s;
        logic  r;
        for (int n = 0; n < 600; n++) begin
            s = stim_t'($urandom);
            s.finish = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 39) == 0);
            drive(s, r);
            #1;
            checks++; if (dp.mem_wdata !== mbus(s.bflag)) begin errors++; $display("FAIL rnd_bus[%0d]: got %h want %h", n, dp.mem_wdata, mbus(s.bflag)); end
            checks++; if (dp.mem_we !== (s.cflag[0] & ~m_halted)) begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", n, dp.mem_we, s.cflag[0] & ~m_halted); end
            tick();
            checks++; if (dp.ac_dbg !== m_ac) begin errors++; $display("FAIL rnd_ac[%0d]: got %h want %h", n, dp.ac_dbg, m_ac); end
            checks++; if (dp.pc_dbg !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, dp.pc_dbg, m_pc); end
            checks++; if (dp.mem_addr !== m_ar) begin errors++; $display("FAIL rnd_ar[%0d]: got %h want %h", n, dp.mem_addr, m_ar); end
            checks++; if (dp.ir !== m_ir) begin errors++; $display("FAIL rnd_ir[%0d]: got %h want %h", n, dp.ir, m_ir); end
            checks++; if (dp.z !== m_z) begin errors++; $display("FAIL rnd_z[%0d]: got %b want %b", n, dp.z, m_z); end
            checks++; if (dp.halted !== m_halted) begin errors++; $display("FAIL rnd_halted[%0d]: got %b want %b", n, dp.halted, m_halted); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        {m_pc, m_ar, m_ir, m_r1, m_r2, m_r3, m_r, m_ac} = '0;
        m_z = 1'b1; m_halted = 1'b0; m_fd = 1'b0;
        test_reset();
        test_fetch();
        test_add_sub();
        test_precedence();
        test_wrap_shift();
        test_store();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
